harq_combine_scheduler: RTL

HARQ_COMBINE_SCHEDULER -- requirements
Module: harq_combine_scheduler

---
 rtl/harq_combine_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/harq_combine_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : harq_combine_scheduler
// Purpose  : Per-slot HARQ combine/drain sequencer with ping-pong buffering.
// Revision : 1.0
// ============================================================================
module harq_combine_scheduler #(
    parameter int          NUM_USERS      = 8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic                    i_core_clk,
    input  logic                    i_rx_rstn,
    input  logic                    i_rdm_slot_start,
    input  logic [NUM_USERS-1:0]    i_user_valid_mask,
    input  logic [16*NUM_USERS-1:0] i_users_ncb,
    output logic                    o_Combine_process_request,
    output logic [3:0]              o_Combine_user_index,
    output logic                    o_Combine_PingPong_Indicator,
    input  logic                    i_current_cb_combine_comp,
    output logic                    o_SENDHARQ_Data_request,
    output logic                    o_SENDHARQ_Data_PingPong_Indicator,
    output logic [15:0]             o_SENDHARQ_Data_ncb,
    input  logic                    i_SENDHARQ_Data_Comp,
    output logic                    o_busy,
    output logic                    o_slot_done,
    output logic                    o_slot_overrun,
    output logic                    o_timeout_err,
    output logic [3:0]              o_skip_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCAN    = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_HANDOFF = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [NUM_USERS-1:0] r_pending;
    logic [3:0]           r_index;
    logic [15:0]          r_ncb;
    logic                 r_pp;
    logic                 r_sh_busy;
    logic [15:0]          r_wdog;
    logic [3:0]           r_skip;
    logic                 r_overrun;
    logic                 r_timeout_err;

    logic                 w_found;
    logic [3:0]           w_sel_idx;
    logic [NUM_USERS-1:0] w_sel_onehot;
    logic [15:0]          w_sel_ncb;
    logic                 w_sel_skip;
    logic                 w_wdog_exp;
    logic                 w_handoff;
    logic                 w_timeout_evt;
    logic [3:0]           w_skip_inc;

    // Descending walk so the last hit is the lowest pending user.
    always_comb begin
        w_found      = 1'b0;
        w_sel_idx    = 4'd0;
        w_sel_onehot = '0;
        w_sel_ncb    = 16'd0;
        for (int k = NUM_USERS - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_found         = 1'b1;
                w_sel_idx       = k[3:0];
                w_sel_onehot    = '0;
                w_sel_onehot[k] = 1'b1;
                w_sel_ncb       = i_users_ncb[k*16 +: 16];
            end
        end
    end

    assign w_sel_skip    = (w_sel_ncb[15:4] == 12'd0);
    assign w_wdog_exp    = (r_wdog == (TIMEOUT_CYCLES - 16'd1));
    assign w_handoff     = (r_state == S_HANDOFF) && !r_sh_busy;
    assign w_timeout_evt = (r_state == S_WAIT) && !i_current_cb_combine_comp && w_wdog_exp;
    assign w_skip_inc    = (r_skip != 4'hF) ? (r_skip + 4'd1) : r_skip;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_rdm_slot_start) w_next_state = S_SCAN;
            S_SCAN: begin
                if (!w_found)        w_next_state = S_DRAIN;
                else if (!w_sel_skip) w_next_state = S_REQ;
            end
            S_REQ:     w_next_state = S_WAIT;
            S_WAIT: begin
                if (i_current_cb_combine_comp) w_next_state = S_HANDOFF;
                else if (w_wdog_exp)           w_next_state = S_SCAN;
            end
            S_HANDOFF: if (!r_sh_busy) w_next_state = S_SCAN;
            S_DRAIN:   if (!r_sh_busy) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_Combine_process_request = (r_state == S_REQ);
        o_SENDHARQ_Data_request   = w_handoff;
        o_busy                    = (r_state != S_IDLE);
        o_slot_done               = (r_state == S_DONE);
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            r_pending     <= '0;
            r_index       <= 4'd0;
            r_ncb         <= 16'd0;
            r_pp          <= 1'b0;
            r_sh_busy     <= 1'b0;
            r_wdog        <= 16'd0;
            r_skip        <= 4'd0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_overrun     <= i_rdm_slot_start && (r_state != S_IDLE);
            r_timeout_err <= w_timeout_evt;

            // At most one drain in flight: the handoff claims the drain engine.
            if (w_handoff) begin
                r_sh_busy <= 1'b1;
                r_pp      <= ~r_pp;
            end else if (i_SENDHARQ_Data_Comp) begin
                r_sh_busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_rdm_slot_start) begin
                        r_pending <= i_user_valid_mask;
                        r_skip    <= 4'd0;
                    end
                end
                S_SCAN: begin
                    if (w_found) begin
                        r_pending <= r_pending & ~w_sel_onehot;
                        if (w_sel_skip) begin
                            r_skip <= w_skip_inc;
                        end else begin
                            r_index <= w_sel_idx;
                            r_ncb   <= w_sel_ncb;
                        end
                    end
                end
                S_REQ:  r_wdog <= 16'd0;
                S_WAIT: begin
                    r_wdog <= r_wdog + 16'd1;
                    if (w_timeout_evt) r_skip <= w_skip_inc;
                end
                default: ;
            endcase
        end
    end

    assign o_Combine_user_index               = r_index;
    assign o_Combine_PingPong_Indicator       = r_pp;
    assign o_SENDHARQ_Data_PingPong_Indicator = r_pp;
    assign o_SENDHARQ_Data_ncb                = r_ncb;
    assign o_slot_overrun                     = r_overrun;
    assign o_timeout_err                      = r_timeout_err;
    assign o_skip_count                       = r_skip;

endmodule
`default_nettype wire
